// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready flow control.
// The sideband tag and the carry, overflow and zero flags travel with each result.
module prefix_adder_pipe #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned TAG_W            = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LOG_W = $clog2(WIDTH);
  localparam int unsigned NS    = (LOG_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Apply the prefix levels lo..hi-1 to a (G,P) vector.
  function automatic logic [2*WIDTH-1:0] ks_span(input logic [WIDTH-1:0] g_in,
                                                 input logic [WIDTH-1:0] p_in,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
    logic [WIDTH-1:0] g, p, gn, pn;
    g = g_in;
    p = p_in;
    for (int unsigned l = 0; l < LOG_W; l++) begin
      if (l >= lo && l < hi) begin
        gn = g;
        pn = p;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (i >= (32'd1 << l)) begin
            gn[i] = g[i] | (p[i] & g[i - (32'd1 << l)]);
            pn[i] = p[i] & p[i - (32'd1 << l)];
          end
        end
        g = gn;
        p = pn;
      end
    end
    return {g, p};
  endfunction

  logic [NS-1:0]                  vld_q, vld_d, c0_q, c0_d;
  logic [NS-1:0][WIDTH-1:0]       g_q, g_d, p_q, p_d, ph_q, ph_d;
  logic [NS-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic                           out_valid_q, out_valid_d;
  logic [WIDTH-1:0]               sum_q, sum_d;
  logic                           cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [TAG_W-1:0]               out_tag_q, out_tag_d;

  logic                           advance_c, c0_in_c;
  logic [WIDTH-1:0]               b_c, gi_c, pi_c, g_t, p_t, carry_c, sum_c;

  // Pipeline moves as one unit; a stalled output freezes every stage.
  always_comb begin
    vld_d       = vld_q;
    c0_d        = c0_q;
    g_d         = g_q;
    p_d         = p_q;
    ph_d        = ph_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_tag_d   = out_tag_q;
    g_t         = '0;
    p_t         = '0;

    advance_c = !out_valid_q || out_ready;
    b_c       = op_sub ? ~y : y;
    c0_in_c   = op_sub | cin;
    gi_c      = x & b_c;
    pi_c      = x ^ b_c;
    // Carry-in is merged into bit 0 so the prefix yields the carry into every bit directly.
    gi_c[0]   = gi_c[0] | (pi_c[0] & c0_in_c);

    {g_t, p_t} = ks_span(g_q[NS-1], p_q[NS-1], (NS-1) * LEVELS_PER_STAGE, LOG_W);
    carry_c    = {g_t[WIDTH-2:0], c0_q[NS-1]};
    sum_c      = ph_q[NS-1] ^ carry_c;

    if (advance_c) begin
      out_valid_d = vld_q[NS-1];
      sum_d       = sum_c;
      cout_d      = g_t[WIDTH-1];
      ovf_d       = carry_c[WIDTH-1] ^ g_t[WIDTH-1];
      zero_d      = (sum_c == '0);
      out_tag_d   = tag_q[NS-1];

      for (int unsigned s = 1; s < NS; s++) begin
        {g_t, p_t} = ks_span(g_q[s-1], p_q[s-1], (s-1) * LEVELS_PER_STAGE, s * LEVELS_PER_STAGE);
        vld_d[s]   = vld_q[s-1];
        c0_d[s]    = c0_q[s-1];
        g_d[s]     = g_t;
        p_d[s]     = p_t;
        ph_d[s]    = ph_q[s-1];
        tag_d[s]   = tag_q[s-1];
      end

      vld_d[0] = in_valid;
      if (in_valid) begin
        c0_d[0]  = c0_in_c;
        g_d[0]   = gi_c;
        p_d[0]   = pi_c;
        ph_d[0]  = pi_c;
        tag_d[0] = in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      c0_q        <= '0;
      g_q         <= '0;
      p_q         <= '0;
      ph_q        <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      vld_q       <= vld_d;
      c0_q        <= c0_d;
      g_q         <= g_d;
      p_q         <= p_d;
      ph_q        <= ph_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = advance_c;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe: directed table, stall, reset flush,
// and random traffic at 32/2, 8/1 and 64/3 configurations.
module tb_prefix_adder_pipe;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
    bit          chk_lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    logic [31:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
    logic        e_zero;
  } vec_t;

  // Main instance: WIDTH=32, LPS=2
  logic        rst, in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] x, y, sum;
  logic [3:0]  in_tag, out_tag;

  prefix_adder_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .cin(cin), .op_sub(op_sub), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .out_tag(out_tag));

  // Auxiliary instances: WIDTH=8/LPS=1 and WIDTH=64/LPS=3
  logic        a8_iv, a8_ir, a8_cin, a8_sub, a8_ov, a8_or, a8_cout, a8_ovf, a8_zero;
  logic [7:0]  a8_x, a8_y, a8_sum;
  logic [3:0]  a8_it, a8_ot;
  logic        a64_iv, a64_ir, a64_cin, a64_sub, a64_ov, a64_or, a64_cout, a64_ovf, a64_zero;
  logic [63:0] a64_x, a64_y, a64_sum;
  logic [3:0]  a64_it, a64_ot;

  prefix_adder_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(a8_iv), .in_ready(a8_ir), .x(a8_x), .y(a8_y),
    .cin(a8_cin), .op_sub(a8_sub), .in_tag(a8_it), .out_valid(a8_ov),
    .out_ready(a8_or), .sum(a8_sum), .cout(a8_cout), .ovf(a8_ovf), .zero(a8_zero), .out_tag(a8_ot));

  prefix_adder_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(3), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(a64_iv), .in_ready(a64_ir), .x(a64_x), .y(a64_y),
    .cin(a64_cin), .op_sub(a64_sub), .in_tag(a64_it), .out_valid(a64_ov),
    .out_ready(a64_or), .sum(a64_sum), .cout(a64_cout), .ovf(a64_ovf), .zero(a64_zero), .out_tag(a64_ot));

  exp_t q[$];
  exp_t q8[$];
  exp_t q64[$];
  exp_t cur_exp, m_e, m8_e, m64_e;
  int   popped = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Behavioural reference: {cout,sum} = x + b + c0 at width w.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] bi,
                                 input logic c, input logic s, input logic [3:0] t);
    logic [64:0] mask, full;
    logic [63:0] am, b;
    logic        c0;
    exp_t        e;
    mask   = (65'd1 << w) - 65'd1;
    am     = a & mask[63:0];
    b      = s ? (~bi & mask[63:0]) : (bi & mask[63:0]);
    c0     = s ? 1'b1 : c;
    full   = {1'b0, am} + {1'b0, b} + 65'(c0);
    e.sum  = full[63:0] & mask[63:0];
    e.cout = full[w];
    e.zero = (e.sum == 64'd0);
    e.ovf  = (am[w-1] == b[w-1]) && (e.sum[w-1] != am[w-1]);
    e.tag  = t;
    e.chk_lat = 1'b0;
    e.acc  = 0;
    return e;
  endfunction

  // Main scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got tag %0h, expected no output", out_tag);
        end else begin
          m_e = q.pop_front();
          check("sum", 64'(sum), m_e.sum);
          check("cout", 64'(cout), 64'(m_e.cout));
          check("ovf", 64'(ovf), 64'(m_e.ovf));
          check("zero", 64'(zero), 64'(m_e.zero));
          check("tag", 64'(out_tag), 64'(m_e.tag));
          if (m_e.chk_lat) check("latency", 64'(cyc - m_e.acc), 64'(LAT));
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        m_e = cur_exp;
        m_e.acc = cyc;
        q.push_back(m_e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
    end else begin
      if (a8_ov && a8_or) begin
        if (q8.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL w8_unexpected_out: got tag %0h, expected no output", a8_ot);
        end else begin
          m8_e = q8.pop_front();
          check("w8_sum", 64'(a8_sum), m8_e.sum);
          check("w8_flags", 64'({a8_cout, a8_ovf, a8_zero, a8_ot}),
                64'({m8_e.cout, m8_e.ovf, m8_e.zero, m8_e.tag}));
        end
      end
      if (a8_iv && a8_ir) q8.push_back(model(8, 64'(a8_x), 64'(a8_y), a8_cin, a8_sub, a8_it));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q64.delete();
    end else begin
      if (a64_ov && a64_or) begin
        if (q64.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL w64_unexpected_out: got tag %0h, expected no output", a64_ot);
        end else begin
          m64_e = q64.pop_front();
          check("w64_sum", a64_sum, m64_e.sum);
          check("w64_flags", 64'({a64_cout, a64_ovf, a64_zero, a64_ot}),
                64'({m64_e.cout, m64_e.ovf, m64_e.zero, m64_e.tag}));
        end
      end
      if (a64_iv && a64_ir) q64.push_back(model(64, a64_x, a64_y, a64_cin, a64_sub, a64_it));
    end
  end

  // Present one beat and hold it until it is accepted.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, input logic [3:0] t, input exp_t e);
    int k;
    x = a; y = b; cin = c; op_sub = s; in_tag = t; cur_exp = e; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || q8.size() != 0 || q64.size() != 0) && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("drain_left", 64'(q.size() + q8.size() + q64.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  exp_t e;
  logic [31:0] snap_sum;
  logic [6:0]  snap_flags;
  int          p0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; cin = 1'b0;
    op_sub = 1'b0; in_tag = '0; cur_exp = model(32, 0, 0, 0, 0, 0);
    a8_iv = 0; a8_or = 1; a8_x = 0; a8_y = 0; a8_cin = 0; a8_sub = 0; a8_it = 0;
    a64_iv = 0; a64_or = 1; a64_x = 0; a64_y = 0; a64_cin = 0; a64_sub = 0; a64_it = 0;

    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", 64'({cout, ovf, zero, out_tag}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    //          x             y             cin   sub   sum           cout  ovf   zero
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      e.sum = 64'(tbl[i].e_sum); e.cout = tbl[i].e_cout; e.ovf = tbl[i].e_ovf;
      e.zero = tbl[i].e_zero; e.tag = 4'(i); e.chk_lat = 1'b1; e.acc = 0;
      drive(tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub, 4'(i), e);
    end
    in_valid = 1'b0;
    drain();

    // 16-beat stream with a 3-cycle output stall in the middle
    p0 = popped;
    fork
      begin
        for (int t = 0; t < 16; t++) begin
          logic [31:0] a, b;
          logic        s;
          a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
          drive(a, b, 1'b1, s, 4'(t), model(32, 64'(a), 64'(b), 1'b1, s, 4'(t)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        snap_sum = sum;
        snap_flags = {cout, ovf, zero, out_tag};
        repeat (2) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_hold_valid", 64'(out_valid), 64'd1);
          check("stall_hold_sum", 64'(sum), 64'(snap_sum));
          check("stall_hold_flags", 64'({cout, ovf, zero, out_tag}), 64'(snap_flags));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(popped - p0), 64'd16);

    // Reset while three beats are in flight
    p0 = popped;
    for (int t = 1; t <= 3; t++)
      drive(32'(t), 32'd100, 1'b0, 1'b0, 4'(t), model(32, 64'(t), 64'd100, 1'b0, 1'b0, 4'(t)));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    e = model(32, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1111_1111, 1'b0, 1'b0, 4'hC);
    e.chk_lat = 1'b1;
    drive(32'hDEADBEEF, 32'h11111111, 1'b0, 1'b0, 4'hC, e);
    in_valid = 1'b0;
    drain();
    check("flush_count", 64'(popped - p0), 64'd1);

    // Random traffic on all three configurations with random backpressure
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      logic        c, s;
      logic [3:0]  t;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
      b = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      t = 4'($urandom);
      x = a; y = b; cin = c; op_sub = s; in_tag = t;
      cur_exp = model(32, 64'(a), 64'(b), c, s, t);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a8_x = 8'($urandom); a8_y = 8'($urandom); a8_cin = 1'($urandom_range(0, 1));
      a8_sub = 1'($urandom_range(0, 1)); a8_it = 4'($urandom);
      a8_iv = ($urandom_range(0, 9) < 7); a8_or = ($urandom_range(0, 9) < 7);
      a64_x = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'($urandom), 32'($urandom)};
      a64_y = {32'($urandom), 32'($urandom)}; a64_cin = 1'($urandom_range(0, 1));
      a64_sub = 1'($urandom_range(0, 1)); a64_it = 4'($urandom);
      a64_iv = ($urandom_range(0, 9) < 7); a64_or = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; a8_iv = 1'b0; a64_iv = 1'b0;
    out_ready = 1'b1; a8_or = 1'b1; a64_or = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
